// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART command codes, parity modes and FSM state encoding
// Used by both the receiver and transmitter banks that share the row/col/action bus.
package uart_pkg;

   // Command codes on the shared action bus; any other value is a NOP.
   localparam logic [3:0] ACT_NOP    = 4'd0;
   localparam logic [3:0] ACT_SETDST = 4'd1;
   localparam logic [3:0] ACT_READ   = 4'd2;
   localparam logic [3:0] ACT_CLR    = 4'd3;
   localparam logic [3:0] ACT_CLRALL = 4'd4;

   // Parity modes for the PAR parameter.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the asynchronous serial line
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized output).
// Resets to 1 so an idle-high line never looks like a start edge after reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_bank.sv
// rtl/uart_rx_bank.sv - UART receiver writing frames into a 2x4 bank of W-bit cells
// Ports: clk, rst (sync, active-high), rx (serial in, idle high),
//        row/col/action (cell command bus), busy (frame in progress),
//        valid/par_err/frame_err (1-cycle result pulses), r_cell (cell at read pointer).
module uart_rx_bank
   import uart_pkg::*;
#(
   parameter int W   = 8,
   parameter int DIV = 3,
   parameter int PAR = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   input  logic         row,
   input  logic [0:1]   col,
   input  logic [3:0]   action,
   output logic         busy,
   output logic         valid,
   output logic         par_err,
   output logic         frame_err,
   output logic [W-1:0] r_cell
);

   localparam int CW = $clog2(DIV + 1);
   localparam int BW = $clog2(W + 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
   localparam logic PAR_IS_ODD = (PAR == PAR_ODD);

   uart_state_t state, state_nx;

   logic          rx_s;
   logic          rx_prev;
   logic [CW-1:0] cnt;
   logic [BW-1:0] nbits;
   logic [W-1:0]  shreg;
   logic          perr;
   logic [2:0]    dst, rd, tgt;
   logic [W-1:0]  cells [0:7];
   logic          tick;
   logic          commit, perr_nx, ferr_nx;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // START samples at mid start bit; every later state samples once per bit,
   // DIV cycles after the previous sample.
   assign tick = (state == ST_START) ? (cnt == HALF) : (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (rx_prev && !rx_s) state_nx = ST_START;
         ST_START:  if (tick) state_nx = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (tick && nbits == LAST_BIT)
                       state_nx = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tick) state_nx = ST_STOP;
         ST_STOP:   if (tick) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != ST_IDLE);
      commit  = (state == ST_STOP) && tick && rx_s && !perr;
      perr_nx = (state == ST_STOP) && tick && rx_s && perr;
      ferr_nx = (state == ST_STOP) && tick && !rx_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_prev   <= 1'b1;
         cnt       <= '0;
         nbits     <= '0;
         shreg     <= '0;
         perr      <= 1'b0;
         dst       <= '0;
         rd        <= '0;
         tgt       <= '0;
         valid     <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < 8; i++) cells[i] <= '0;
      end else begin
         rx_prev   <= rx_s;
         valid     <= commit;
         par_err   <= perr_nx;
         frame_err <= ferr_nx;

         // The edge-detect cycle is cycle 0 of the start bit, so START begins at 1.
         if (state == ST_IDLE) cnt <= CW'(1);
         else if (tick)        cnt <= '0;
         else                  cnt <= cnt + CW'(1);

         if (state == ST_START && tick && !rx_s) begin
            tgt   <= dst;
            nbits <= '0;
            perr  <= 1'b0;
         end
         if (state == ST_DATA && tick) begin
            shreg <= {rx_s, shreg[W-1:1]};
            nbits <= nbits + BW'(1);
         end
         if (state == ST_PARITY && tick)
            perr <= ((^shreg) ^ rx_s) != PAR_IS_ODD;

         case (action)
            ACT_SETDST: dst <= {row, col};
            ACT_READ:   rd  <= {row, col};
            ACT_CLR:    cells[{row, col}] <= '0;
            ACT_CLRALL: for (int i = 0; i < 8; i++) cells[i] <= '0;
            default:    ;
         endcase

         // Placed after the clears so a commit to the same cell wins.
         if (commit) cells[tgt] <= shreg;
      end
   end

   assign r_cell = cells[rd];

endmodule

// File: tb/tb_uart_rx_bank.sv
// tb/tb_uart_rx_bank.sv - self-checking bench for uart_rx_bank (PAR=0 and PAR=1 instances)
module tb_uart_rx_bank;
   import uart_pkg::*;

   localparam int DIV = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx0 = 1'b1;
   logic       rx1 = 1'b1;
   logic       row = 1'b0;
   logic [0:1] col = 2'b00;
   logic [3:0] action = ACT_NOP;

   logic       busy0, valid0, perr0, ferr0;
   logic [7:0] rcell0;
   logic       busy1, valid1, perr1, ferr1;
   logic [7:0] rcell1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         inst;
      int         kind;   // 0 valid, 1 par_err, 2 frame_err
      logic [7:0] data;
   } ev_t;
   ev_t sb[$];

   always #5 clk = ~clk;

   uart_rx_bank #(.W(8), .DIV(DIV), .PAR(0)) dut (
      .clk(clk), .rst(rst), .rx(rx0), .row(row), .col(col), .action(action),
      .busy(busy0), .valid(valid0), .par_err(perr0), .frame_err(ferr0), .r_cell(rcell0)
   );

   uart_rx_bank #(.W(8), .DIV(DIV), .PAR(1)) dut_p (
      .clk(clk), .rst(rst), .rx(rx1), .row(row), .col(col), .action(action),
      .busy(busy1), .valid(valid1), .par_err(perr1), .frame_err(ferr1), .r_cell(rcell1)
   );

   logic [1:0] v_a, p_a, f_a;
   logic [7:0] rc_a [2];
   assign v_a = {valid1, valid0};
   assign p_a = {perr1, perr0};
   assign f_a = {ferr1, ferr0};
   assign rc_a[0] = rcell0;
   assign rc_a[1] = rcell1;

   // Scoreboard: every result pulse must match the oldest expected event.
   ev_t ev;
   int  kind;
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (v_a[i] || p_a[i] || f_a[i]) begin
               kind = v_a[i] ? 0 : (p_a[i] ? 1 : 2);
               n_checks++;
               if ((int'(v_a[i]) + int'(p_a[i]) + int'(f_a[i])) != 1) begin
                  n_fail++;
                  $display("FAIL pulse_exclusive inst%0d: v=%b p=%b f=%b, required exactly one",
                           i, v_a[i], p_a[i], f_a[i]);
               end else if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected inst%0d: got kind %0d, required no pulse", i, kind);
               end else begin
                  ev = sb.pop_front();
                  if (ev.inst != i || ev.kind != kind) begin
                     n_fail++;
                     $display("FAIL sb_event: got inst%0d kind %0d, required inst%0d kind %0d",
                              i, kind, ev.inst, ev.kind);
                  end else if (kind == 0) begin
                     n_checks++;
                     if (rc_a[i] !== ev.data) begin
                        n_fail++;
                        $display("FAIL sb_data inst%0d: r_cell=%h, required %h", i, rc_a[i], ev.data);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic set_rx(input int inst, input logic v);
      if (inst == 0) rx0 = v;
      else           rx1 = v;
   endtask

   task automatic bit_out(input int inst, input logic b);
      set_rx(inst, b);
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [3:0] a, input logic r, input logic [1:0] c);
      action = a;
      row    = r;
      col    = c;
      @(posedge clk);
      #1;
      action = ACT_NOP;
   endtask

   task automatic drive_bits(input int inst, input logic [7:0] d, input int nb,
                             input bit haspar, input logic pb);
      bit_out(inst, 1'b0);
      for (int k = 0; k < nb; k++) bit_out(inst, d[k]);
      if (haspar) bit_out(inst, pb);
   endtask

   task automatic send(input int inst, input logic [7:0] d, input bit haspar,
                       input logic pb, input logic stop);
      drive_bits(inst, d, 8, haspar, pb);
      bit_out(inst, stop);
      bit_out(inst, 1'b1);
   endtask

   task automatic push(input int inst, input int k, input logic [7:0] d);
      ev_t e;
      e.inst = inst;
      e.kind = k;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({busy0, valid0, perr0, ferr0} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: busy/valid/par/frame=%b, required 0000",
                  {busy0, valid0, perr0, ferr0});
      end
      n_checks++;
      if (rcell0 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rcell: r_cell=%h, required 00", rcell0);
      end
      for (int c = 0; c < 8; c++) begin
         cmd(ACT_READ, c[2], c[1:0]);
         n_checks++;
         if (rcell0 !== 8'h00 || rcell1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cell%0d: r_cell=%h/%h, required 00", c, rcell0, rcell1);
         end
      end
   endtask

   task automatic test_basic();
      cmd(ACT_SETDST, 1'b0, 2'd2);
      cmd(ACT_READ, 1'b0, 2'd2);
      push(0, 0, 8'hA5);
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (rcell0 !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_cell: r_cell=%h, required a5", rcell0);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL basic_pending: %0d events outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_parity();
      push(1, 1, 8'h00);
      send(1, 8'h03, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (rcell1 !== 8'h00) begin
         n_fail++;
         $display("FAIL parity_drop: r_cell=%h, required 00", rcell1);
      end
      push(1, 0, 8'h03);
      send(1, 8'h03, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (rcell1 !== 8'h03) begin
         n_fail++;
         $display("FAIL parity_good: r_cell=%h, required 03", rcell1);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL parity_pending: %0d events outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_framing();
      push(0, 2, 8'h00);
      drive_bits(0, 8'h5A, 8, 1'b0, 1'b0);
      bit_out(0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         bit_out(0, 1'b0);
         n_checks++;
         if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_hold_low%0d: busy=%b, required 0", k, busy0);
         end
      end
      n_checks++;
      if (rcell0 !== 8'hA5) begin
         n_fail++;
         $display("FAIL framing_keep: r_cell=%h, required a5", rcell0);
      end
      bit_out(0, 1'b1);
      bit_out(0, 1'b1);
      push(0, 0, 8'h11);
      send(0, 8'h11, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (rcell0 !== 8'h11) begin
         n_fail++;
         $display("FAIL framing_recover: r_cell=%h, required 11", rcell0);
      end
   endtask

   task automatic test_glitch_and_clr();
      bit saw_busy;
      rx0 = 1'b0;
      @(posedge clk);
      #1;
      rx0 = 1'b1;
      saw_busy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (busy0) saw_busy = 1'b1;
      end
      n_checks++;
      if (saw_busy !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy: saw_busy=%b end_busy=%b, required 1 then 0", saw_busy, busy0);
      end
      n_checks++;
      if (rcell0 !== 8'h11) begin
         n_fail++;
         $display("FAIL glitch_keep: r_cell=%h, required 11", rcell0);
      end
      // CLR lands on the same edge that commits 0x33 into cell (0,2).
      push(0, 0, 8'h33);
      drive_bits(0, 8'h33, 8, 1'b0, 1'b0);
      rx0 = 1'b1;
      repeat (DIV) @(posedge clk);
      #1;
      action = ACT_CLR;
      row    = 1'b0;
      col    = 2'd2;
      @(posedge clk);
      #1;
      action = ACT_NOP;
      bit_out(0, 1'b1);
      n_checks++;
      if (rcell0 !== 8'h33) begin
         n_fail++;
         $display("FAIL clr_vs_commit: r_cell=%h, required 33", rcell0);
      end
      cmd(ACT_CLR, 1'b0, 2'd2);
      n_checks++;
      if (rcell0 !== 8'h00) begin
         n_fail++;
         $display("FAIL clr_plain: r_cell=%h, required 00", rcell0);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_pending: %0d events outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_rst_mid_frame();
      push(0, 0, 8'h44);
      send(0, 8'h44, 1'b0, 1'b0, 1'b1);
      drive_bits(0, 8'h3C, 4, 1'b0, 1'b0);
      rx0 = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_busy: busy=%b, required 1", busy0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (busy0 !== 1'b0 || rcell0 !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid: busy=%b r_cell=%h, required 0/00", busy0, rcell0);
      end
      cmd(ACT_READ, 1'b0, 2'd2);
      n_checks++;
      if (rcell0 !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_cell_cleared: r_cell=%h, required 00", rcell0);
      end
      repeat (6) @(posedge clk);
      #1;
      cmd(ACT_READ, 1'b0, 2'd0);
      push(0, 0, 8'h7E);
      send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (rcell0 !== 8'h7E) begin
         n_fail++;
         $display("FAIL rst_after_frame: r_cell=%h, required 7e", rcell0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch_and_clr();
      test_rst_mid_frame();
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL final_pending: %0d events outstanding, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
